// File: rtl/inst_issue.sv
// Instruction sequencer ahead of the PE data memory: stores a streamed program and
// replays it loop_cnt times, issuing inst_v/rden and the delayed wben strobe without collisions.
module inst_issue #(
    parameter int INST_WIDTH = 32,
    parameter int IM_DEPTH   = 16,
    parameter int WB_LAT     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_v,
    input  logic [INST_WIDTH-1:0] load_inst,
    input  logic                  start,
    input  logic [7:0]            loop_cnt,
    input  logic                  hold,
    output logic                  inst_v,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  rden,
    output logic                  wben,
    output logic                  busy,
    output logic                  done
);

    localparam int PW  = $clog2(IM_DEPTH);
    localparam int CW  = PW + 1;
    localparam int SRW = WB_LAT - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [INST_WIDTH-1:0] im [IM_DEPTH];
    logic [CW-1:0]         load_ptr_q, load_ptr_d;
    logic [CW-1:0]         prog_len_q, prog_len_d;
    logic [PW-1:0]         pc_q, pc_d;
    logic [7:0]            iter_q, iter_d;
    logic [7:0]            iter_max_q, iter_max_d;
    logic                  inst_v_q, inst_v_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic                  saw_wb_q, saw_wb_d;
    logic                  done_q, done_d;
    logic [SRW-1:0]        wb_sr_q, wb_sr_d;
    logic [SRW-1:0]        vld_sr_q, vld_sr_d;
    logic                  wben_q;
    logic                  im_we;
    logic                  issue;
    logic                  last_pc;
    logic                  drain_empty;

    // The top shift stage becomes wben next cycle, so it is the only collision source.
    assign issue   = (state_q == S_RUN) && !hold && !wb_sr_q[SRW-1];
    assign last_pc = ({1'b0, pc_q} == (prog_len_q - CW'(1)));

    // With write-backs in flight, finish right after the last wben; a program with no
    // wb flags instead waits out the full write-back latency of its last issue.
    assign drain_empty = saw_wb_q ? ((wb_sr_q == '0) && !(inst_v_q && inst_q[INST_WIDTH-1]))
                                  : ((vld_sr_q == '0) && !inst_v_q);

    assign wb_sr_d  = (wb_sr_q << 1) | SRW'(inst_v_q & inst_q[INST_WIDTH-1]);
    assign vld_sr_d = (vld_sr_q << 1) | SRW'(inst_v_q);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        prog_len_d = prog_len_q;
        pc_d       = pc_q;
        iter_d     = iter_q;
        iter_max_d = iter_max_q;
        inst_v_d   = 1'b0;
        inst_d     = inst_q;
        saw_wb_d   = saw_wb_q;
        done_d     = 1'b0;
        im_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (prog_len_q != '0)) begin
                    state_d    = S_RUN;
                    pc_d       = '0;
                    iter_d     = 8'd0;
                    iter_max_d = (loop_cnt == 8'd0) ? 8'd0 : loop_cnt - 8'd1;
                    load_ptr_d = '0;
                    saw_wb_d   = 1'b0;
                end else if (load_v && (load_ptr_q != CW'(IM_DEPTH))) begin
                    im_we      = 1'b1;
                    load_ptr_d = load_ptr_q + CW'(1);
                    prog_len_d = load_ptr_q + CW'(1);
                end
            end
            S_RUN: begin
                if (issue) begin
                    inst_v_d = 1'b1;
                    inst_d   = im[pc_q];
                    if (inst_d[INST_WIDTH-1]) saw_wb_d = 1'b1;
                    if (last_pc) begin
                        pc_d   = '0;
                        iter_d = iter_q + 8'd1;
                        if (iter_q == iter_max_q) state_d = S_DRAIN;
                    end else begin
                        pc_d = pc_q + PW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_empty) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the program store has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (im_we) im[load_ptr_q[PW-1:0]] <= load_inst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            load_ptr_q <= '0;
            // A reset that aborts a run keeps the program loaded so it can be replayed.
            if (state_q == S_IDLE) prog_len_q <= '0;
            pc_q       <= '0;
            iter_q     <= 8'd0;
            iter_max_q <= 8'd0;
            inst_v_q   <= 1'b0;
            inst_q     <= '0;
            saw_wb_q   <= 1'b0;
            done_q     <= 1'b0;
            wb_sr_q    <= '0;
            vld_sr_q   <= '0;
            wben_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
            prog_len_q <= prog_len_d;
            pc_q       <= pc_d;
            iter_q     <= iter_d;
            iter_max_q <= iter_max_d;
            inst_v_q   <= inst_v_d;
            inst_q     <= inst_d;
            saw_wb_q   <= saw_wb_d;
            done_q     <= done_d;
            wb_sr_q    <= wb_sr_d;
            vld_sr_q   <= vld_sr_d;
            wben_q     <= wb_sr_q[SRW-1];
        end
    end

    assign inst_v = inst_v_q;
    assign rden   = inst_v_q;
    assign inst   = inst_q;
    assign wben   = wben_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;

endmodule

// File: doc/inst_issue.md
# inst_issue

Instruction sequencer that sits directly upstream of the PE data memory. It holds a small program loaded over a streaming port. On `start` it replays that program a programmable number of times. It drives the data memory's `inst_v`/`inst`/`rden` issue interface and generates the delayed `wben` write-back strobe, and it never lets an issue collide with a write-back.

## Interface
Parameters:
- `INST_WIDTH`, 32: instruction width. Field layout:
  - [31] wb flag (1 = result is written back)
  - [30:24] opcode
  - [23:16] src2 address
  - [15:8] src1 address
  - [7:0] destination address
- `IM_DEPTH`, 16: instruction memory entries (power of two).
- `WB_LAT`, 5: cycles from an issued `inst_v` to its `wben`; minimum 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `load_v`  in  1  program word valid; accepted only in IDLE.
- `load_inst`  in  INST_WIDTH  program word.
- `start`  in  1  begin execution; accepted only in IDLE with prog_len>0.
- `loop_cnt`  in  8  iteration count, sampled with `start`; 0 is treated as 1.
- `hold`  in  1  external stall (data memory busy loading via wea).
- `inst_v`  out  1  instruction valid to data memory.
- `inst`  out  INST_WIDTH  issued instruction.
- `rden`  out  1  operand read enable; identical to `inst_v`.
- `wben`  out  1  write-back enable.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse on completion.

## Operation
- Instruction memory `im[IM_DEPTH]`: content retained across `rst`.
- `load_ptr` and `prog_len` reset to 0.
- In IDLE, when `load_v` is high:
  - `im[load_ptr] <= load_inst`, `load_ptr++`.
  - `prog_len` saturates at IM_DEPTH.
  - Words beyond IM_DEPTH are dropped.
- Pulsing `start` with `prog_len=0` is ignored.
- States:
  - IDLE → RUN on `start && prog_len!=0`. At that transition, `pc<=0`, `iter<=0`, `iter_max<=max(loop_cnt,1)-1`, and `load_ptr<=0` so the next load starts a new program.
  - RUN → DRAIN after the issue of `im[prog_len-1]` with `iter==iter_max`.
  - DRAIN → IDLE when the write-back shift register is empty. `done` pulses in the first IDLE cycle.
- Issue rule (RUN): an instruction issues in a cycle when all of the following hold:
  - `hold` was low in the previous cycle.
  - The write-back pipe will not assert `wben` in the issue cycle.
- On issue:
  - Outputs: `inst<=im[pc]`, `inst_v<=1`, `rden<=1`.
  - If `pc==prog_len-1`, then `pc<=0` and `iter++`; otherwise `pc++`.
- Non-issue cycles: `inst_v=rden=0`, and `inst` holds its last value.
- Write-back pipe: a WB_LAT-deep shift register loaded with `inst_v & inst[31]`. `wben` is its registered output.
- Invariant: `inst_v && wben` is never true in the same cycle. On conflict, the issue is deferred by one cycle; `pc` is not advanced.
- `load_v` outside IDLE is ignored. `start` outside IDLE is ignored.

## Timing
- Cycle n means the cycle after clock edge n.
- Reset values:
  - Outputs: `inst_v=0`, `inst=0`, `rden=0`, `wben=0`, `busy=0`, `done=0`.
  - State: IDLE, shift register cleared.
- `start` high in cycle 0 → `busy=1` in cycle 1 → first `inst_v` (`im[0]`) in cycle 2 if it is not blocked.
- `hold` high in cycle n blocks issue in cycle n+1. Issue resumes in the cycle after `hold` falls.
- An `inst_v` with wb=1 in cycle n gives `wben=1` in cycle n+WB_LAT.
- `done` is asserted for exactly one cycle, in the cycle after the last `wben`. If the program has no wb flags, `done` is asserted WB_LAT+1 cycles after the last issue. `busy` falls in the same cycle that `done` rises.
- `rst` mid-RUN or mid-DRAIN:
  - The next cycle is IDLE with all outputs 0.
  - Pending `wben`s are discarded.
  - `done` is not pulsed.
- Unblocked throughput: one instruction per cycle, less one cycle per colliding write-back.

## Test plan
- Load 3 words (0x80030201, 0x80060504, 0x00090807), then `start` with `loop_cnt=1` and `hold=0` → `inst_v` carries the three words in cycles 2, 3, 4.
  - Cycle 7: `wben` for the first word; no `inst_v`.
  - Cycle 8: `wben` for the second word.
  - `done` in cycle 9.
- Same program with `loop_cnt=3` → 9 issues in pc order 0,1,2,0,1,2,0,1,2 and 6 `wben` pulses. `inst_v&wben` is never seen. `done` pulses once.
- 2-word program, all wb=1, `loop_cnt=8` → every cycle in which `wben=1` has `inst_v=0`; 16 issues and 16 `wben`s in total.
- `hold` high in cycles 3–5 during a run → no `inst_v` in cycles 4–6; issue resumes in cycle 7 with the next pc and no word is skipped.
- `rst` asserted in cycle 4 of a run → from cycle 5: `busy=0`, `wben=0`, no `done`. A following `start` (with no reload) replays `im` from pc 0.
- `start` with `prog_len=0` → `busy` stays 0. 20 `load_v` words with IM_DEPTH=16 → `prog_len=16` and words 16–19 are dropped.
